// File: rtl/nios_system_led_fader_pkg.sv
// nios_system_led_fader_pkg: default parameters and width helpers shared by the LED fader.
package nios_system_led_fader_pkg;
    localparam int DEF_NUM_LEDS          = 16;
    localparam int DEF_PWM_BITS          = 8;
    localparam int DEF_PRESCALE          = 195;
    localparam int DEF_FADE_STEP_PERIODS = 1;

    // A counter that only ever holds 0 still needs one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int lvl_max(input int bits);
        return (1 << bits) - 1;
    endfunction
endpackage

// File: rtl/nios_system_led_fade_timebase.sv
// nios_system_led_fade_timebase: prescaler, PWM counter and fade-step counter, all frozen while disabled.
module nios_system_led_fade_timebase
    import nios_system_led_fader_pkg::*;
#(
    parameter int PWM_BITS          = DEF_PWM_BITS,
    parameter int PRESCALE          = DEF_PRESCALE,
    parameter int FADE_STEP_PERIODS = DEF_FADE_STEP_PERIODS
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_enable,
    output logic [PWM_BITS-1:0] o_pwm_cnt,
    output logic                o_step_tick
);
    localparam int PW = clog2_min1(PRESCALE);
    localparam int SW = clog2_min1(FADE_STEP_PERIODS);

    logic [PW-1:0]       r_presc;
    logic [SW-1:0]       r_step;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic                w_pwm_tick;
    logic                w_period_end;

    assign w_pwm_tick   = i_enable && (r_presc == PW'(PRESCALE - 1));
    assign w_period_end = w_pwm_tick && (&r_pwm_cnt);
    assign o_step_tick  = w_period_end && (r_step == SW'(FADE_STEP_PERIODS - 1));
    assign o_pwm_cnt    = r_pwm_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_presc   <= '0;
            r_pwm_cnt <= '0;
            r_step    <= '0;
        end else if (i_enable) begin
            r_presc <= w_pwm_tick ? '0 : r_presc + 1'b1;
            if (w_pwm_tick)
                r_pwm_cnt <= r_pwm_cnt + 1'b1;
            if (w_period_end)
                r_step <= o_step_tick ? '0 : r_step + 1'b1;
        end
    end
endmodule

// File: rtl/nios_system_led_fader.sv
// nios_system_led_fader: ramps each LED's PWM brightness toward its PIO target state.
module nios_system_led_fader
    import nios_system_led_fader_pkg::*;
#(
    parameter int NUM_LEDS          = DEF_NUM_LEDS,
    parameter int PWM_BITS          = DEF_PWM_BITS,
    parameter int PRESCALE          = DEF_PRESCALE,
    parameter int FADE_STEP_PERIODS = DEF_FADE_STEP_PERIODS
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_LEDS-1:0] led_in,
    input  logic                enable,
    input  logic                fade_bypass,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                busy
);
    localparam logic [PWM_BITS-1:0] LVL_MAX = PWM_BITS'(lvl_max(PWM_BITS));

    logic [NUM_LEDS-1:0] r_led_in_q;
    logic [NUM_LEDS-1:0] w_diff;
    logic [NUM_LEDS-1:0] w_on;
    logic [PWM_BITS-1:0] w_pwm_cnt;
    logic                w_step_tick;

    nios_system_led_fade_timebase #(
        .PWM_BITS          (PWM_BITS),
        .PRESCALE          (PRESCALE),
        .FADE_STEP_PERIODS (FADE_STEP_PERIODS)
    ) u_timebase (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_enable    (enable),
        .o_pwm_cnt   (w_pwm_cnt),
        .o_step_tick (w_step_tick)
    );

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
        logic [PWM_BITS-1:0] r_level;
        logic [PWM_BITS-1:0] w_tgt;
        assign w_tgt     = r_led_in_q[i] ? LVL_MAX : '0;
        assign w_diff[i] = r_level != w_tgt;
        // Full scale is forced on so the top level never shows a one-step gap per period.
        assign w_on[i]   = (r_level == LVL_MAX) || (r_level > w_pwm_cnt);
        always_ff @(posedge clk) begin
            if (!reset_n)
                r_level <= '0;
            else if (enable) begin
                if (fade_bypass)
                    r_level <= w_tgt;
                else if (w_step_tick && w_diff[i])
                    r_level <= r_led_in_q[i] ? r_level + 1'b1 : r_level - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_led_in_q <= '0;
            led_out    <= '0;
            busy       <= 1'b0;
        end else begin
            r_led_in_q <= led_in;
            led_out    <= enable ? w_on : '0;
            busy       <= |w_diff;
        end
    end
endmodule

// File: tb/tb_nios_system_led_fader.sv
// tb_nios_system_led_fader: directed fade scenarios checked against a time-based brightness model.
module tb_nios_system_led_fader;
    localparam int P   = 2;
    localparam int LM  = 15;
    localparam int PER = P * 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b1;
    logic        fade_bypass = 1'b0;
    logic [15:0] led_in = 16'hFFFF;
    logic [15:0] led_out;
    logic        busy;

    int checks = 0;
    int fails  = 0;
    bit chk    = 1'b0;

    // Model: time is counted in enabled clocks; PWM count and step instants follow from it.
    int          m_lvl [16];
    logic [15:0] m_q = '0;
    logic [15:0] m_out = '0;
    logic        m_busy = 1'b0;
    int          m_en = 0;
    int          pc;
    int          tgt;
    bit          st;
    logic [15:0] o;
    logic        b;

    always #5 clk = ~clk;

    nios_system_led_fader #(
        .NUM_LEDS          (16),
        .PWM_BITS          (4),
        .PRESCALE          (P),
        .FADE_STEP_PERIODS (1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .led_in      (led_in),
        .enable      (enable),
        .fade_bypass (fade_bypass),
        .led_out     (led_out),
        .busy        (busy)
    );

    always @(posedge clk) begin
        if (!reset_n) begin
            m_q = '0;
            m_out = '0;
            m_busy = 1'b0;
            m_en = 0;
            for (int i = 0; i < 16; i++) m_lvl[i] = 0;
        end else begin
            pc = (m_en / P) % 16;
            st = enable && (m_en % PER == PER - 1);
            b = 1'b0;
            for (int i = 0; i < 16; i++) begin
                tgt = m_q[i] ? LM : 0;
                o[i] = enable && (m_lvl[i] == LM || m_lvl[i] > pc);
                b = b | (m_lvl[i] != tgt);
                if (enable) begin
                    if (fade_bypass) m_lvl[i] = tgt;
                    else if (st && m_lvl[i] < tgt) m_lvl[i] = m_lvl[i] + 1;
                    else if (st && m_lvl[i] > tgt) m_lvl[i] = m_lvl[i] - 1;
                end
            end
            m_out = o;
            m_busy = b;
            if (enable) m_en = m_en + 1;
            m_q = led_in;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk) begin
            check("model_led_out", led_out, m_out);
            check("model_busy", busy, m_busy);
        end
    end

    task automatic window(input int exp, input string name);
        int n = 0;
        repeat (PER) begin
            @(negedge clk);
            n += int'(led_out[0]);
        end
        check(name, n, exp);
    endtask

    task automatic wait_lvl(input int l, input int bound);
        int n;
        for (n = 0; n < bound; n++) begin
            @(negedge clk);
            if (m_lvl[0] == l) break;
        end
        checks++;
        if (n == bound) begin
            fails++;
            $display("FAIL wait_lvl: level %0d not reached within %0d clk", l, bound);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (4) begin
            @(negedge clk);
            chk = 1'b1;
            check("rst_led_out", led_out, 0);
            check("rst_busy", busy, 0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        check("rel_led_out", led_out, 0);
        check("rel_busy", busy, 0);

        fade_bypass = 1'b1;
        led_in = 16'h0000;
        repeat (5) @(negedge clk);
        check("byp_clear", led_out, 0);
        led_in = 16'h00A5;
        repeat (2) @(negedge clk);
        check("byp_lat2", led_out, 0);
        @(negedge clk);
        check("byp_lat3", led_out, 16'h00A5);
        repeat (5) begin
            @(negedge clk);
            check("byp_hold", led_out, 16'h00A5);
            check("byp_busy", busy, 0);
        end

        led_in = 16'h0000;
        repeat (4) @(negedge clk);
        fade_bypass = 1'b0;
        led_in = 16'h0001;
        wait_lvl(1, 40);
        check("fade_busy_on", busy, 1);
        for (int l = 1; l <= LM; l++) window(l == LM ? 32 : 2 * l, "fade_up_duty");
        check("fade_busy_off", busy, 0);
        check("fade_others", led_out[15:1], 0);

        fade_bypass = 1'b1;
        led_in = 16'h0000;
        repeat (4) @(negedge clk);
        fade_bypass = 1'b0;
        led_in = 16'h0001;
        wait_lvl(8, 300);
        led_in = 16'h0000;
        wait_lvl(7, 40);
        for (int l = 7; l >= 0; l--) window(2 * l, "rev_duty");
        check("rev_busy_off", busy, 0);

        led_in = 16'h0001;
        wait_lvl(5, 200);
        enable = 1'b0;
        @(negedge clk);
        check("frz_next", led_out, 0);
        n = 0;
        repeat (99) begin
            @(negedge clk);
            n += int'(led_out != 0);
        end
        check("frz_dark", n, 0);
        check("frz_busy", busy, 1);
        enable = 1'b1;
        window(10, "frz_duty5");
        window(12, "frz_resume6");

        wait_lvl(9, 200);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_led_out", led_out, 0);
        check("mid_rst_busy", busy, 0);
        reset_n = 1'b1;
        window(0, "refade_l0");
        window(2, "refade_l1");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
